// File: rtl/accel_seq_pkg.sv
// Shared types and constants for the accelerometer axis sequencer.
package accel_seq_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ABS,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    AXIS_X = 2'd0,
    AXIS_Y = 2'd1,
    AXIS_Z = 2'd2
  } axis_e;

endpackage

// File: rtl/abs_lane.sv
// Combinational two's-complement magnitude, shared by all three axes.
// Optional macro ACCEL_ABS_SATURATE_EN clamps the 0x8000 corner case to 0x7FFF.
module abs_lane
  import accel_seq_pkg::*;
(
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] mag_o
);

  logic [DATA_W-1:0] neg;

  assign neg = ~din_i + DATA_W'(1);

`ifdef ACCEL_ABS_SATURATE_EN
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  assign mag_o = !din_i[DATA_W-1] ? din_i :
                 (din_i == MOST_NEG) ? MOST_POS : neg;
`else
  // Negating the most negative value wraps back to itself, which is intended here.
  assign mag_o = din_i[DATA_W-1] ? neg : din_i;
`endif

endmodule

// File: rtl/accel_axis_sequencer.sv
// Periodic X/Y/Z sampler over one read channel with a single shared abs lane.
// Honours ACCEL_ABS_SATURATE_EN through the abs_lane instance.
module accel_axis_sequencer
  import accel_seq_pkg::*;
#(
  parameter int SAMPLE_DIV  = 100000,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rd_req,
  output logic [1:0]        rd_axis,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] x_data,
  output logic [DATA_W-1:0] y_data,
  output logic [DATA_W-1:0] z_data,
  output logic              sample_valid,
  output logic              busy,
  output logic              timeout_err,
  output logic              overrun
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ACK_TIMEOUT - 1);

  state_e            state_q, state_d;
  axis_e             axis_q, axis_d;
  logic [CNT_W-1:0]  tick_cnt_q;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0] raw_q, raw_d;
  logic [DATA_W-1:0] shx_q, shx_d, shy_q, shy_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic              terr_q, terr_d;
  logic [DATA_W-1:0] mag;
  logic              tick;

  abs_lane u_abs_lane (
    .din_i (raw_q),
    .mag_o (mag)
  );

  assign tick = en && (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (!en || tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      axis_q   <= AXIS_X;
      to_cnt_q <= '0;
      raw_q    <= '0;
      shx_q    <= '0;
      shy_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      axis_q   <= axis_d;
      to_cnt_q <= to_cnt_d;
      raw_q    <= raw_d;
      shx_q    <= shx_d;
      shy_q    <= shy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      terr_q   <= terr_d;
    end
  end

  // Z's magnitude goes straight to the output together with the X/Y shadows, so
  // all three outputs land on the edge entering DONE, aligned with sample_valid.
  always_comb begin
    state_d  = state_q;
    axis_d   = axis_q;
    to_cnt_d = to_cnt_q;
    raw_d    = raw_q;
    shx_d    = shx_q;
    shy_d    = shy_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    terr_d   = terr_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_d  = REQ;
            axis_d   = AXIS_X;
            to_cnt_d = '0;
          end
        end
        REQ: begin
          if (rd_ack) begin
            raw_d   = rd_data;
            state_d = ABS;
          end else if (to_cnt_q == TO_LAST) begin
            state_d = IDLE;
            terr_d  = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        ABS: begin
          to_cnt_d = '0;
          case (axis_q)
            AXIS_X: begin
              shx_d   = mag;
              axis_d  = AXIS_Y;
              state_d = REQ;
            end
            AXIS_Y: begin
              shy_d   = mag;
              axis_d  = AXIS_Z;
              state_d = REQ;
            end
            default: begin
              x_d     = shx_q;
              y_d     = shy_q;
              z_d     = mag;
              terr_d  = 1'b0;
              state_d = DONE;
            end
          endcase
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign rd_req       = (state_q == REQ);
  assign rd_axis      = axis_q;
  assign x_data       = x_q;
  assign y_data       = y_q;
  assign z_data       = z_q;
  assign sample_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign timeout_err  = terr_q;
  assign overrun      = tick && (state_q != IDLE);

endmodule

// File: tb/tb_accel_axis_sequencer.sv
// Scoreboard bench for accel_axis_sequencer: directed frames, responder model, monitor.
module tb_accel_axis_sequencer;

  localparam int SAMPLE_DIV  = 16;
  localparam int ACK_TIMEOUT = 14;
`ifdef ACCEL_ABS_SATURATE_EN
  localparam logic [15:0] MAG_8000 = 16'h7FFF;
`else
  localparam logic [15:0] MAG_8000 = 16'h8000;
`endif

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    int          latency;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rd_req;
  logic [1:0]  rd_axis;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic [15:0] x_data, y_data, z_data;
  logic        sample_valid, busy, timeout_err, overrun;

  accel_axis_sequencer #(
    .SAMPLE_DIV  (SAMPLE_DIV),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .rd_req       (rd_req),
    .rd_axis      (rd_axis),
    .rd_ack       (rd_ack),
    .rd_data      (rd_data),
    .x_data       (x_data),
    .y_data       (y_data),
    .z_data       (z_data),
    .sample_valid (sample_valid),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   passes = 0;
  exp_t sbQ[$];

  logic [15:0] axVal[4];
  int          axDelay[4];
  logic        respAck = 1'b0;
  logic [15:0] respData = '0;
  logic        spurAck;
  logic [15:0] spurData;

  int frameStartCyc = 0;
  int svCount = 0;
  int overrunCount = 0;
  int lastReqLen[4] = '{0, 0, 0, 0};

  assign rd_ack  = respAck | spurAck;
  assign rd_data = spurAck ? spurData : respData;

  task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [15:0] xv, input logic [15:0] yv, input logic [15:0] zv,
                               input int xd, input int yd, input int zd);
    axVal[0] = xv;  axVal[1] = yv;  axVal[2] = zv;  axVal[3] = '0;
    axDelay[0] = xd; axDelay[1] = yd; axDelay[2] = zd; axDelay[3] = 0;
  endtask

  task automatic pushExpect(input logic [15:0] xv, input logic [15:0] yv, input logic [15:0] zv, input int lat);
    exp_t e;
    e.x = xv; e.y = yv; e.z = zv; e.latency = lat;
    sbQ.push_back(e);
  endtask

  task automatic waitSv(input int maxCyc);
    int start = svCount;
    int n = 0;
    while (svCount == start && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    if (svCount == start) checkOutput("sample_valid wait", 0, 1);
  endtask

  // Sensor reader model: acks after axDelay[axis] wait cycles of a request
  initial begin
    int reqRunR = 0;
    forever begin
      @(negedge clk);
      respAck = 1'b0;
      if (rd_req && !rst) begin
        if (reqRunR == axDelay[rd_axis]) begin
          respAck  = 1'b1;
          respData = axVal[rd_axis];
        end
        reqRunR++;
      end else begin
        reqRunR = 0;
      end
    end
  end

  // Monitor: pops expectations on sample_valid and guards output stability
  initial begin
    exp_t        e;
    logic [15:0] prevX = '0, prevY = '0, prevZ = '0;
    logic        rdReqPrev = 1'b0;
    int          reqRun = 0;
    logic [1:0]  reqAxis = 2'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rdReqPrev = 1'b0;
        reqRun    = 0;
      end else begin
        if (rd_req && !rdReqPrev && rd_axis == 2'd0) frameStartCyc = cyc;
        if (rd_req) begin
          reqRun++;
          reqAxis = rd_axis;
        end else if (reqRun > 0) begin
          lastReqLen[reqAxis] = reqRun;
          reqRun = 0;
        end
        rdReqPrev = rd_req;
        if (overrun) overrunCount++;
        if (sample_valid) begin
          if (sbQ.size() == 0) begin
            checkOutput("unexpected sample_valid", 48'd1, 48'd0);
          end else begin
            e = sbQ.pop_front();
            checkOutput("x_data", x_data, e.x);
            checkOutput("y_data", y_data, e.y);
            checkOutput("z_data", z_data, e.z);
            checkOutput("latency rd_req->sample_valid", cyc - frameStartCyc, e.latency);
          end
          svCount++;
        end else begin
          checkOutput("outputs held without sample_valid", {x_data, y_data, z_data}, {prevX, prevY, prevZ});
        end
      end
      prevX = x_data;
      prevY = y_data;
      prevZ = z_data;
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int enCyc, f5Start, ovBefore, n;
    rst = 1'b1; en = 1'b0; spurAck = 1'b0; spurData = '0;
    applyStimulus(16'h0, 16'h0, 16'h0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("reset rd_req/busy/sv", {rd_req, busy, sample_valid}, 0);
    checkOutput("reset err/overrun/axis", {timeout_err, overrun, rd_axis}, 0);
    checkOutput("reset outputs", {x_data, y_data, z_data}, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] frame 1: zero-wait acks");
    applyStimulus(16'h0100, 16'hFF00, 16'h8000, 0, 0, 0);
    pushExpect(16'h0100, 16'h0100, MAG_8000, 6);
    en = 1'b1; enCyc = cyc;
    waitSv(40);
    checkOutput("first rd_req at tick+1", frameStartCyc - enCyc, SAMPLE_DIV);

    $display("[TB] frame 2: Y ack delayed 5");
    applyStimulus(16'h1234, 16'hFFFF, 16'h0000, 0, 5, 0);
    pushExpect(16'h1234, 16'h0001, 16'h0000, 11);
    waitSv(40);
    checkOutput("Y rd_req held cycles", lastReqLen[1], 6);

    $display("[TB] frame 3: Z never acked");
    applyStimulus(16'hFFFE, 16'h7FFF, 16'h1111, 0, 0, 255);
    ovBefore = overrunCount;
    n = 0;
    while (!timeout_err && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout_err set", timeout_err, 1);
    @(negedge clk);
    checkOutput("Z rd_req held until timeout", lastReqLen[2], ACK_TIMEOUT);
    checkOutput("outputs kept after abort", {x_data, y_data, z_data}, {16'h1234, 16'h0001, 16'h0000});
    checkOutput("idle after abort", {busy, rd_req}, 0);
    checkOutput("overrun during long frame", overrunCount - ovBefore, 1);

    $display("[TB] frame 4: good frame clears error");
    applyStimulus(16'h8001, 16'h0005, 16'hFF80, 0, 0, 0);
    pushExpect(16'h7FFF, 16'h0005, 16'h0080, 6);
    waitSv(40);
    @(negedge clk);
    checkOutput("timeout_err cleared", timeout_err, 0);

    $display("[TB] frame 5: X ack delayed 12");
    applyStimulus(16'h0001, 16'hFFF0, 16'h4000, 12, 0, 0);
    pushExpect(16'h0001, 16'h0010, 16'h4000, 18);
    ovBefore = overrunCount;
    waitSv(60);
    checkOutput("overrun pulses once", overrunCount - ovBefore, 1);
    f5Start = frameStartCyc;

    $display("[TB] frame 6: next tick after overrun");
    applyStimulus(16'hC000, 16'h0003, 16'h8000, 0, 0, 0);
    pushExpect(16'h4000, 16'h0003, MAG_8000, 6);
    waitSv(40);
    checkOutput("frame start after dropped tick", frameStartCyc - f5Start, 2 * SAMPLE_DIV);

    $display("[TB] frame 7: en dropped in ABS of Y");
    applyStimulus(16'h0AAA, 16'h0BBB, 16'h0CCC, 0, 0, 0);
    n = 0;
    while (!(rd_req && rd_axis == 2'd1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached REQ of Y", {rd_req, rd_axis}, 3'b101);
    @(negedge clk);
    checkOutput("in ABS of Y", {busy, rd_req}, 2'b10);
    en = 1'b0;
    @(negedge clk);
    checkOutput("idle after en drop", {busy, rd_req}, 0);
    repeat (20) @(negedge clk);
    checkOutput("outputs kept after en drop", {x_data, y_data, z_data}, {16'h4000, 16'h0003, MAG_8000});

    $display("[TB] frame 8: re-enable");
    applyStimulus(16'h7FFF, 16'h8000, 16'h0001, 0, 0, 0);
    pushExpect(16'h7FFF, MAG_8000, 16'h0001, 6);
    en = 1'b1; enCyc = cyc;
    waitSv(40);
    checkOutput("counter restarts after re-enable", frameStartCyc - enCyc, SAMPLE_DIV);

    $display("[TB] frame 9: async reset mid-request");
    applyStimulus(16'h5555, 16'h0000, 16'h0000, 255, 0, 0);
    n = 0;
    while (!rd_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rd_req before reset", rd_req, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("async reset rd_req/busy/sv", {rd_req, busy, sample_valid}, 0);
    checkOutput("async reset outputs", {x_data, y_data, z_data}, 0);
    checkOutput("async reset timeout_err", timeout_err, 0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    spurData = 16'hFFFF; spurAck = 1'b1;
    @(negedge clk);
    spurAck = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("spurious ack ignored", {busy, rd_req}, 0);
    checkOutput("outputs after spurious ack", {x_data, y_data, z_data}, 0);

    checkOutput("scoreboard drained", sbQ.size(), 0);
    checkOutput("total overruns", overrunCount, 2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/accel_axis_sequencer.md
Name: accel_axis_sequencer

Overview:
- Periodically samples the three accelerometer axes through a single read channel: X, then Y, then Z.
- Converts each raw two's-complement axis word to its magnitude using one shared absolute-value lane.
- Publishes all three magnitudes together, with a one-cycle valid strobe.
- Sits between the sensor read interface (SPI/I2C reader) and the motion/threshold logic, replacing three parallel abs converters.

Parameters:
- SAMPLE_DIV, 100000, clk cycles between sample-frame starts (minimum 16).
- ACK_TIMEOUT, 255, max cycles rd_req may wait for rd_ack before the frame aborts.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  sequencer enable
- rd_req  out  1  read request to sensor reader
- rd_axis  out  2  axis select: 0=X, 1=Y, 2=Z (3 never driven)
- rd_ack  in  1  one-cycle acknowledge; rd_data is valid in the same cycle
- rd_data  in  16  raw two's-complement axis sample
- x_data  out  16  X magnitude
- y_data  out  16  Y magnitude
- z_data  out  16  Z magnitude
- sample_valid  out  1  one-cycle strobe when x/y/z_data update
- busy  out  1  high while a frame is in progress
- timeout_err  out  1  sticky; set on ack timeout, cleared by the next completed frame
- overrun  out  1  one-cycle pulse when a tick arrives while busy

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0, state IDLE.
  - Tick counter and timeout counter cleared.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 while en=1; the tick is the cycle the count equals SAMPLE_DIV-1, then it wraps to 0.
  - Held at 0 while en=0.
- States:
  - IDLE: wait for tick → REQ, axis=X.
  - REQ: rd_req=1, rd_axis stable.
    - If rd_ack=1 this cycle: capture rd_data → ABS.
    - Else if the timeout count reaches ACK_TIMEOUT: → IDLE, timeout_err=1, shadow discarded.
  - ABS: shared lane writes the magnitude into the axis shadow register. Then X→REQ(Y), Y→REQ(Z), Z→DONE.
  - DONE: copy the shadows to x/y/z_data and raise sample_valid on the same edge; → IDLE; timeout_err cleared.
- Handshake:
  - rd_req drops in the cycle after the ack.
  - rd_ack while rd_req=0 is ignored.
  - The timeout counter restarts on each REQ entry.
- Latency, with the tick at cycle T and ack on the first REQ cycle of every axis:
  - rd_req rises at T+1.
  - sample_valid is high at T+7 only.
- Magnitude rule:
  - Input bit15=0: pass through.
  - Input bit15=1: ~d+1, 16-bit wrap. 0x8000 → 0x8000, 0xFFFF → 0x0001, 0x0000 → 0x0000.
- Outputs:
  - Outputs only ever change together, never partially.
  - Aborted frames leave them unchanged.
- Tick while busy: the tick is dropped, overrun pulses for 1 cycle, and the frame continues.
- en falls mid-frame: → IDLE next cycle, rd_req=0, outputs and timeout_err retained, no sample_valid.
- busy = state≠IDLE.

Optional Feature:
- Macro: ACCEL_ABS_SATURATE_EN.
- Defined: input 0x8000 produces 0x7FFF, so the magnitude is always ≤ 32767.
- Undefined: 0x8000 → 0x8000, per the wrap rule above.
- All other values are identical either way.

Decomposition:
- Package accel_seq_pkg:
  - State enum: IDLE, REQ, ABS, DONE.
  - Axis codes: AXIS_X=0, AXIS_Y=1, AXIS_Z=2.
  - DATA_W=16.
- Sub-module abs_lane:
  - Combinational 16-bit magnitude, including the saturate option.
  - One instance, shared across the three axes.

Test Plan:
- Reset then en=1, SAMPLE_DIV=16, zero-wait ack returning X=0x0100, Y=0xFF00, Z=0x8000 → sample_valid 1 cycle at tick+7; x=0x0100, y=0x0100, z=0x8000 (0x7FFF with ACCEL_ABS_SATURATE_EN).
- Ack delayed 5 cycles on Y → rd_req held with rd_axis=1 for 6 cycles; sample_valid at tick+12; outputs update atomically.
- No ack on Z, ACK_TIMEOUT=8 → rd_req drops after 8 cycles, timeout_err=1, outputs keep the prior frame; the next good frame clears timeout_err.
- SAMPLE_DIV=16 with ack delay 12 → overrun pulses once, that frame still completes, the next frame starts on the following tick.
- en dropped during ABS of Y → IDLE next cycle, no sample_valid, outputs unchanged; re-enable → the counter restarts from 0.
- rst asserted mid-REQ (asynchronous, between edges) → all outputs 0 immediately, including rd_req; a spurious rd_ack in IDLE is ignored.
